// File: rtl/serializer_pkg.sv
// Shared types and elaboration helpers for the buffered bit serializer.
package serializer_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    // Clock cycles per serial bit.
    function automatic int unsigned calc_divide(input int unsigned sys_freq,
                                                input int unsigned bit_rate);
        return sys_freq / bit_rate;
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 32'd0) && ((value & (value - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/buffered_bit_serializer_checker.sv
// Elaboration-time parameter checks for the buffered bit serializer.
module buffered_bit_serializer_checker
    import serializer_pkg::*;
#(
    parameter int unsigned WORD_LENGTH = 16,
    parameter int unsigned DIVIDE      = 100,
    parameter int unsigned FIFO_DEPTH  = 4
) ();

    generate
        if (DIVIDE < 32'd2) begin : g_bad_divide
            $error("buffered_bit_serializer: DIVIDE must be >= 2");
        end
        if (!is_pow2(FIFO_DEPTH) || (FIFO_DEPTH < 32'd2)) begin : g_bad_depth
            $error("buffered_bit_serializer: FIFO_DEPTH must be a power of two >= 2");
        end
        if (WORD_LENGTH < 32'd2) begin : g_bad_word
            $error("buffered_bit_serializer: WORD_LENGTH must be >= 2");
        end
    endgenerate

endmodule

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO with wrap-bit pointers and a synchronous flush.
module sync_word_fifo
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                           clock_i,
    input  logic                           reset_i,
    input  logic                           clear_i,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wr_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rd_data,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // A flush wins over any push or pop in the same cycle; a full FIFO refuses pushes.
    assign push_ok_s = push && !full && !clear_i;
    assign pop_ok_s  = pop && !empty && !clear_i;

    assign empty   = (wr_ptr_r == rd_ptr_r);
    assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign level   = wr_ptr_r - rd_ptr_r;
    assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

    // Pointer update with asynchronous reset and synchronous flush.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (clear_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Storage array write port; contents are only meaningful between the pointers.
    always_ff @(posedge clock_i) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/buffered_bit_serializer.sv
// Buffered serializer: FIFO-fed shift register producing a gapless serial audio stream.
module buffered_bit_serializer
    import serializer_pkg::*;
#(
    parameter int unsigned WORD_LENGTH      = 16,
    parameter int unsigned SYSTEM_FREQUENCY = 100000000,
    parameter int unsigned BIT_RATE         = 1000000,
    parameter int unsigned FIFO_DEPTH       = 4,
    parameter bit          MSB_FIRST        = 1'b1,
    parameter logic        IDLE_LEVEL       = 1'b0
) (
    input  logic                                clock_i,
    input  logic                                reset_i,
    input  logic                                enable_i,
    input  logic                                clear_i,
    input  logic [WORD_LENGTH-1:0]              data_i,
    input  logic                                valid_i,
    output logic                                ready_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     level_o,
    output logic                                serial_o,
    output logic                                busy_o,
    output logic                                word_done_o,
    output logic                                underrun_o
);

    localparam int unsigned DIVIDE = calc_divide(SYSTEM_FREQUENCY, BIT_RATE);
    localparam int unsigned DIV_W  = $clog2(DIVIDE);
    localparam int unsigned BIT_W  = $clog2(WORD_LENGTH);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(DIVIDE - 32'd1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_LENGTH - 32'd1);

    ser_state_e               state_r;
    ser_state_e               state_nxt_s;
    logic [DIV_W-1:0]         div_cnt_r;
    logic [BIT_W-1:0]         bit_cnt_r;
    logic [WORD_LENGTH-1:0]   shift_r;
    logic                     serial_r;
    logic                     word_done_r;
    logic                     underrun_r;

    logic [WORD_LENGTH-1:0]   head_s;
    logic                     fifo_full_s;
    logic                     fifo_empty_s;
    logic                     bit_end_s;
    logic                     word_end_s;
    logic                     start_s;
    logic                     pop_s;
    logic                     load_s;
    logic                     advance_s;
    logic                     done_s;
    logic                     underrun_s;
    logic                     first_bit_s;
    logic                     next_bit_s;

    buffered_bit_serializer_checker #(
        .WORD_LENGTH (WORD_LENGTH),
        .DIVIDE      (DIVIDE),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) u_checker ();

    sync_word_fifo #(
        .WIDTH (WORD_LENGTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clear_i (clear_i),
        .push    (valid_i),
        .wr_data (data_i),
        .pop     (pop_s),
        .rd_data (head_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .level   (level_o)
    );

    // End of a bit period, end of a word, and whether a new word may start now.
    assign bit_end_s  = (state_r == SHIFT) && (div_cnt_r == DIV_MAX);
    assign word_end_s = bit_end_s && (bit_cnt_r == {BIT_W{1'b0}});
    assign start_s    = enable_i && !fifo_empty_s && ((state_r == IDLE) || word_end_s);

    // First bit of the head word and next bit of the shift register, in transmit order.
    assign first_bit_s = MSB_FIRST ? head_s[WORD_LENGTH-1] : head_s[0];
    assign next_bit_s  = MSB_FIRST ? shift_r[WORD_LENGTH-2] : shift_r[1];

    // FSM state register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: a word starts when one is buffered, and the FSM idles only when no follow-on word loads.
    always_comb begin
        state_nxt_s = state_r;
        if (clear_i) begin
            state_nxt_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        state_nxt_s = SHIFT;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                SHIFT: begin
                    if (word_end_s && !start_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = SHIFT;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // FSM outputs: pop/load, bit advance and end-of-word event pulses; a flush suppresses them all.
    always_comb begin
        pop_s      = 1'b0;
        load_s     = 1'b0;
        advance_s  = 1'b0;
        done_s     = 1'b0;
        underrun_s = 1'b0;
        if (clear_i) begin
            pop_s      = 1'b0;
            load_s     = 1'b0;
            advance_s  = 1'b0;
            done_s     = 1'b0;
            underrun_s = 1'b0;
        end else begin
            pop_s      = start_s;
            load_s     = start_s;
            advance_s  = bit_end_s && (bit_cnt_r != {BIT_W{1'b0}});
            done_s     = word_end_s;
            underrun_s = word_end_s && enable_i && fifo_empty_s;
        end
    end

    // Datapath: shift register, divider, bit counter, registered serial pin and event pulses.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            shift_r     <= '0;
            div_cnt_r   <= '0;
            bit_cnt_r   <= '0;
            serial_r    <= IDLE_LEVEL;
            word_done_r <= 1'b0;
            underrun_r  <= 1'b0;
        end else if (clear_i) begin
            shift_r     <= '0;
            div_cnt_r   <= '0;
            bit_cnt_r   <= '0;
            serial_r    <= IDLE_LEVEL;
            word_done_r <= 1'b0;
            underrun_r  <= 1'b0;
        end else begin
            word_done_r <= done_s;
            underrun_r  <= underrun_s;
            if (load_s) begin
                shift_r   <= head_s;
                serial_r  <= first_bit_s;
                bit_cnt_r <= BIT_LAST;
                div_cnt_r <= '0;
            end else if (advance_s) begin
                shift_r   <= MSB_FIRST ? {shift_r[WORD_LENGTH-2:0], 1'b0}
                                       : {1'b0, shift_r[WORD_LENGTH-1:1]};
                serial_r  <= next_bit_s;
                bit_cnt_r <= bit_cnt_r - {{(BIT_W-1){1'b0}}, 1'b1};
                div_cnt_r <= '0;
            end else if (word_end_s) begin
                serial_r  <= IDLE_LEVEL;
                bit_cnt_r <= '0;
                div_cnt_r <= '0;
            end else if (state_r == SHIFT) begin
                div_cnt_r <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
            end else begin
                serial_r  <= IDLE_LEVEL;
                div_cnt_r <= '0;
            end
        end
    end

    assign ready_o     = !fifo_full_s;
    assign busy_o      = (state_r == SHIFT);
    assign serial_o    = serial_r;
    assign word_done_o = word_done_r;
    assign underrun_o  = underrun_r;

endmodule

// File: tb/tb_buffered_bit_serializer.sv
// Randomised and directed bench for buffered_bit_serializer against a queue-based stream model.
module tb_buffered_bit_serializer;

    localparam int WL    = 16;
    localparam int SF    = 100;
    localparam int BR    = 10;
    localparam int DIV   = SF / BR;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clock_i = 1'b0;
    logic          reset_i;
    logic          enable_i;
    logic          clear_i;
    logic          valid_i;
    logic [WL-1:0] data_i;

    logic          m_ready, m_serial, m_busy, m_done, m_under;
    logic [LW-1:0] m_level;
    logic          l_ready, l_serial, l_busy, l_done, l_under;
    logic [LW-1:0] l_level;

    int checks = 0;
    int errors = 0;

    buffered_bit_serializer #(
        .WORD_LENGTH (WL), .SYSTEM_FREQUENCY (SF), .BIT_RATE (BR),
        .FIFO_DEPTH (DEPTH), .MSB_FIRST (1'b1), .IDLE_LEVEL (1'b0)
    ) dut_m (
        .clock_i (clock_i), .reset_i (reset_i), .enable_i (enable_i), .clear_i (clear_i),
        .data_i (data_i), .valid_i (valid_i), .ready_o (m_ready), .level_o (m_level),
        .serial_o (m_serial), .busy_o (m_busy), .word_done_o (m_done), .underrun_o (m_under)
    );

    buffered_bit_serializer #(
        .WORD_LENGTH (WL), .SYSTEM_FREQUENCY (SF), .BIT_RATE (BR),
        .FIFO_DEPTH (DEPTH), .MSB_FIRST (1'b0), .IDLE_LEVEL (1'b1)
    ) dut_l (
        .clock_i (clock_i), .reset_i (reset_i), .enable_i (enable_i), .clear_i (clear_i),
        .data_i (data_i), .valid_i (valid_i), .ready_o (l_ready), .level_o (l_level),
        .serial_o (l_serial), .busy_o (l_busy), .word_done_o (l_done), .underrun_o (l_under)
    );

    always #5 clock_i = ~clock_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: buffered words, the word on the wire and the cycle index inside it.
    logic [WL-1:0] q[$];
    bit            act_b   = 1'b0;
    logic [WL-1:0] word    = '0;
    int            tw      = 0;
    bit            e_done  = 1'b0;
    bit            e_under = 1'b0;
    bit            can_push;
    bit            nonempty;

    function automatic logic bit_of(input bit msb);
        int k;
        k = tw / DIV;
        return msb ? word[WL-1-k] : word[k];
    endfunction

    // Advance the model by one clock, or clear it on reset.
    always @(posedge clock_i or posedge reset_i) begin
        if (reset_i || clear_i) begin
            q.delete();
            act_b   = 1'b0;
            tw      = 0;
            e_done  = 1'b0;
            e_under = 1'b0;
        end else begin
            can_push = valid_i && (q.size() < DEPTH);
            nonempty = (q.size() > 0);
            e_done   = 1'b0;
            e_under  = 1'b0;
            if (!act_b) begin
                if (enable_i && nonempty) begin
                    word  = q.pop_front();
                    act_b = 1'b1;
                    tw    = 0;
                end
            end else if (tw == WL * DIV - 1) begin
                e_done = 1'b1;
                if (enable_i && nonempty) begin
                    word = q.pop_front();
                    tw   = 0;
                end else begin
                    act_b   = 1'b0;
                    e_under = enable_i;
                end
            end else begin
                tw++;
            end
            if (can_push) q.push_back(data_i);
        end
    end

    // Compare both DUTs with the model every cycle.
    always @(negedge clock_i) begin
        check("m_serial", m_serial, act_b ? bit_of(1'b1) : 1'b0);
        check("l_serial", l_serial, act_b ? bit_of(1'b0) : 1'b1);
        check("m_busy",   m_busy,   act_b);
        check("l_busy",   l_busy,   act_b);
        check("m_level",  m_level,  q.size());
        check("l_level",  l_level,  q.size());
        check("m_ready",  m_ready,  q.size() < DEPTH);
        check("l_ready",  l_ready,  q.size() < DEPTH);
        check("m_done",   m_done,   e_done);
        check("l_done",   l_done,   e_done);
        check("m_under",  m_under,  e_under);
        check("l_under",  l_under,  e_under);
    end

    task automatic tick(input logic v, input logic [WL-1:0] d, input logic en, input logic clr);
        valid_i  = v;
        data_i   = d;
        enable_i = en;
        clear_i  = clr;
        @(posedge clock_i);
        #2;
    endtask

    logic [WL-1:0] pat;
    int n_busy, n_done, n_under, first_idle, rate;
    logic en_r;

    initial begin
        reset_i = 1'b1; valid_i = 1'b0; data_i = '0; enable_i = 1'b0; clear_i = 1'b0;
        repeat (3) tick(1'b0, '0, 1'b0, 1'b0);
        check("rst_ready", m_ready, 1'b1);
        check("rst_level", m_level, 0);
        check("rst_serial_m", m_serial, 1'b0);
        check("rst_serial_l", l_serial, 1'b1);
        check("rst_busy", m_busy, 1'b0);
        check("rst_done", m_done, 1'b0);
        reset_i = 1'b0;
        repeat (3) tick(1'b0, '0, 1'b1, 1'b0);

        // Single word A5C3, MSB first: first bit two cycles after the push.
        pat = 16'hA5C3;
        tick(1'b1, 16'hA5C3, 1'b1, 1'b0);
        check("t1_pop_pending", m_busy, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);
        for (int n = 0; n < 160; n++) begin
            check("t1_bit", m_serial, pat[15 - n / 10]);
            check("t1_no_done", m_done, 1'b0);
            tick(1'b0, '0, 1'b1, 1'b0);
        end
        check("t1_done", m_done, 1'b1);
        check("t1_under", m_under, 1'b1);
        check("t1_idle", m_serial, 1'b0);
        check("t1_busy", m_busy, 1'b0);
        repeat (5) tick(1'b0, '0, 1'b1, 1'b0);

        // Two back-to-back words with no gap; enable drops during the second word.
        tick(1'b1, 16'hA5C3, 1'b1, 1'b0);
        tick(1'b1, 16'h00FF, 1'b1, 1'b0);
        n_busy = 0; n_done = 0; n_under = 0; first_idle = -1;
        for (int i = 0; i < 340; i++) begin
            if (m_busy) n_busy++;
            else if (first_idle < 0) first_idle = i;
            if (m_done) n_done++;
            if (m_under) n_under++;
            tick(1'b0, '0, (i < 200), 1'b0);
        end
        check("t2_busy_cycles", n_busy, 320);
        check("t2_first_idle", first_idle, 320);
        check("t2_done_count", n_done, 2);
        check("t2_under_count", n_under, 0);

        // LSB-first word 0001: high for one bit period, then low.
        tick(1'b1, 16'h0001, 1'b1, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);
        for (int n = 0; n < 160; n++) begin
            check("t3_bit", l_serial, (n < 10) ? 1'b1 : 1'b0);
            tick(1'b0, '0, 1'b1, 1'b0);
        end
        repeat (5) tick(1'b0, '0, 1'b0, 1'b0);

        // Fill with enable low, then drain.
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 16'h1000 + WL'(i), 1'b0, 1'b0);
            check("t4_level", m_level, (i + 1 < DEPTH) ? i + 1 : DEPTH);
            check("t4_ready", m_ready, (i + 1 < DEPTH) ? 1'b1 : 1'b0);
        end
        tick(1'b0, '0, 1'b1, 1'b0);
        check("t4_ready_back", m_ready, 1'b1);
        check("t4_level_pop", m_level, 3);
        repeat (4 * 160 + 10) tick(1'b0, '0, 1'b1, 1'b0);
        check("t4_drained", m_level, 0);
        check("t4_idle", m_busy, 1'b0);
        repeat (3) tick(1'b0, '0, 1'b0, 1'b0);

        // Enable dropped mid-word: the word completes, no underrun.
        tick(1'b1, 16'hBEEF, 1'b1, 1'b0);
        tick(1'b0, '0, 1'b1, 1'b0);
        repeat (50) tick(1'b0, '0, 1'b1, 1'b0);
        n_done = 0; n_under = 0; n_busy = 0;
        for (int i = 0; i < 120; i++) begin
            if (m_busy) n_busy++;
            if (m_done) n_done++;
            if (m_under) n_under++;
            tick(1'b0, '0, 1'b0, 1'b0);
        end
        check("t5_remaining", n_busy, 110);
        check("t5_done", n_done, 1);
        check("t5_under", n_under, 0);

        // Clear mid-word with a simultaneous push.
        tick(1'b1, 16'h5A5A, 1'b1, 1'b0);
        tick(1'b1, 16'h1234, 1'b1, 1'b0);
        repeat (30) tick(1'b0, '0, 1'b1, 1'b0);
        tick(1'b1, 16'h7777, 1'b1, 1'b1);
        check("t6_clr_serial_m", m_serial, 1'b0);
        check("t6_clr_serial_l", l_serial, 1'b1);
        check("t6_clr_level", m_level, 0);
        check("t6_clr_busy", m_busy, 1'b0);
        check("t6_clr_done", m_done, 1'b0);
        repeat (3) tick(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset mid-word, observed before any clock edge.
        tick(1'b1, 16'h5A5A, 1'b1, 1'b0);
        tick(1'b1, 16'hFFFF, 1'b1, 1'b0);
        repeat (30) tick(1'b0, '0, 1'b1, 1'b0);
        reset_i = 1'b1;
        #1;
        check("t6_rst_serial_m", m_serial, 1'b0);
        check("t6_rst_serial_l", l_serial, 1'b1);
        check("t6_rst_busy", m_busy, 1'b0);
        check("t6_rst_level", m_level, 0);
        check("t6_rst_ready", m_ready, 1'b1);
        tick(1'b0, '0, 1'b0, 1'b0);
        reset_i = 1'b0;
        repeat (3) tick(1'b0, '0, 1'b1, 1'b0);

        // Randomised traffic at varying push rates with enable, clear and reset events.
        en_r = 1'b1;
        for (int seg = 0; seg < 6; seg++) begin
            case (seg)
                0: rate = 1;
                1: rate = 100;
                2: rate = 3;
                3: rate = 40;
                4: rate = 1;
                default: rate = 10;
            endcase
            for (int c = 0; c < 1000; c++) begin
                if ($urandom_range(0, 199) == 0) en_r = ~en_r;
                if ($urandom_range(0, 1499) == 0) begin
                    reset_i = 1'b1;
                    tick(1'b0, '0, en_r, 1'b0);
                    reset_i = 1'b0;
                end else begin
                    tick($urandom_range(0, 99) < rate, WL'($urandom),
                         en_r, $urandom_range(0, 499) == 0);
                end
            end
        end
        repeat (3) tick(1'b0, '0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
